// File: rtl/fp_multiplier_pkg.sv
// Shared types, flag indices, default format constants and the canonical-NaN helper
// for the pipelined floating-point multiplier.
package fp_multiplier_pkg;

    typedef enum logic [1:0] {
        FpZero,
        FpNormal,
        FpInf,
        FpNan
    } fp_class_e;

    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    localparam int BF16_EXP_WIDTH = 8;
    localparam int BF16_MAN_WIDTH = 7;
    localparam int BF16_EXP_BIAS  = -127;
    localparam int FP32_EXP_WIDTH = 8;
    localparam int FP32_MAN_WIDTH = 23;
    localparam int FP32_EXP_BIAS  = -127;

    // Quiet NaN with sign 0, exponent all-ones and only the mantissa MSB set.
    function automatic logic [63:0] canonical_nan(input int unsigned exp_width,
                                                  input int unsigned man_width);
        logic [63:0] exp_ones;
        exp_ones = (64'(1) << exp_width) - 64'(1);
        return (exp_ones << man_width) | (64'(1) << (man_width - 1));
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise, round-to-nearest-even, overflow/underflow and pack.
// Flag outputs exist only when FP_MULTIPLIER_PIPE_FLAGS_EN is defined.
module fp_round_pack
    import fp_multiplier_pkg::*;
#(
    parameter int IN_MAN_WIDTH   = 7,
    parameter int OUT_EXP_WIDTH  = 8,
    parameter int OUT_MAN_WIDTH  = 23,
    parameter int EXP_WIDTH      = 11,
    localparam int PROD_WIDTH    = 2 * (IN_MAN_WIDTH + 1),
    localparam int OUT_WIDTH     = 1 + OUT_EXP_WIDTH + OUT_MAN_WIDTH
) (
    input  logic                  special_nan,
    input  logic                  special_inf,
    input  logic                  special_zero,
    input  logic                  sign,
    input  logic [EXP_WIDTH-1:0]  exp_sum,
    input  logic [PROD_WIDTH-1:0] prod,
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    output logic [3:0]            flags,
`endif
    output logic [OUT_WIDTH-1:0]  y
);

    localparam int FW = PROD_WIDTH - 1;
    localparam logic [OUT_WIDTH-1:0] QNAN = OUT_WIDTH'(canonical_nan(OUT_EXP_WIDTH, OUT_MAN_WIDTH));
    localparam logic [EXP_WIDTH-1:0] EXP_MAX = EXP_WIDTH'((1 << OUT_EXP_WIDTH) - 1);

    logic [FW-1:0]            frac;
    logic [OUT_MAN_WIDTH-1:0] man_trunc;
    logic [OUT_MAN_WIDTH:0]   man_sum;
    logic                     round_up;
    logic                     carry;
    logic [EXP_WIDTH-1:0]     exp_final;
    logic                     overflow;
    logic                     underflow;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    logic                     round_inexact;
`endif

    // Drop the leading one; a product in [2,4) already has it one place higher.
    assign frac = prod[PROD_WIDTH-1] ? prod[FW-1:0] : {prod[FW-2:0], 1'b0};

    if (FW <= OUT_MAN_WIDTH) begin : g_exact
        assign man_trunc = OUT_MAN_WIDTH'(frac) << (OUT_MAN_WIDTH - FW);
        assign round_up  = 1'b0;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
        assign round_inexact = 1'b0;
`endif
    end else begin : g_rne
        localparam int DW = FW - OUT_MAN_WIDTH;
        logic [DW-1:0] rem;
        logic [DW-1:0] rem_low;
        assign man_trunc = frac[FW-1 -: OUT_MAN_WIDTH];
        assign rem       = frac[DW-1:0];
        assign rem_low   = rem << 1;
        assign round_up  = rem[DW-1] && ((|rem_low) || man_trunc[0]);
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
        assign round_inexact = |rem;
`endif
    end

    // A carry out of the mantissa leaves it all-zero, i.e. 1.0 at the next exponent.
    assign man_sum   = {1'b0, man_trunc} + {{OUT_MAN_WIDTH{1'b0}}, round_up};
    assign carry     = man_sum[OUT_MAN_WIDTH];
    assign exp_final = exp_sum + EXP_WIDTH'(prod[PROD_WIDTH-1]) + EXP_WIDTH'(carry);
    assign underflow = exp_final[EXP_WIDTH-1] || (exp_final == '0);
    assign overflow  = !exp_final[EXP_WIDTH-1] && (exp_final >= EXP_MAX);

    always_comb begin
        y = {sign, exp_final[OUT_EXP_WIDTH-1:0], man_sum[OUT_MAN_WIDTH-1:0]};
        if (special_nan) begin
            y = QNAN;
        end else if (special_inf || overflow && !special_zero) begin
            y = {sign, {OUT_EXP_WIDTH{1'b1}}, {OUT_MAN_WIDTH{1'b0}}};
        end else if (special_zero || underflow) begin
            y = {sign, {(OUT_WIDTH-1){1'b0}}};
        end
    end

`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    logic normal_path;
    assign normal_path = !special_nan && !special_inf && !special_zero;

    always_comb begin
        flags                 = '0;
        flags[FLAG_INVALID]   = special_nan;
        flags[FLAG_OVERFLOW]  = normal_path && overflow;
        flags[FLAG_UNDERFLOW] = normal_path && underflow;
        flags[FLAG_INEXACT]   = normal_path && (overflow || underflow || round_inexact);
    end
`endif

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Pipelined floating-point multiplier with valid/ready stream ports and a global stall enable.
// Define FP_MULTIPLIER_PIPE_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fp_multiplier_pipe
    import fp_multiplier_pkg::*;
#(
    parameter int INPUT_EXPONENT_WIDTH  = BF16_EXP_WIDTH,
    parameter int INPUT_MANTISSA_WIDTH  = BF16_MAN_WIDTH,
    parameter int INPUT_EXPONENT_BIAS   = BF16_EXP_BIAS,
    parameter int OUTPUT_EXPONENT_WIDTH = FP32_EXP_WIDTH,
    parameter int OUTPUT_MANTISSA_WIDTH = FP32_MAN_WIDTH,
    parameter int OUTPUT_EXPONENT_BIAS  = FP32_EXP_BIAS,
    parameter int PIPE_STAGES           = 2,
    localparam int INPUT_WIDTH  = 1 + INPUT_EXPONENT_WIDTH + INPUT_MANTISSA_WIDTH,
    localparam int OUTPUT_WIDTH = 1 + OUTPUT_EXPONENT_WIDTH + OUTPUT_MANTISSA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  a,
    input  logic [INPUT_WIDTH-1:0]  b,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    output logic [3:0]              flags,
`endif
    output logic [OUTPUT_WIDTH-1:0] y
);

    localparam int IEW = INPUT_EXPONENT_WIDTH;
    localparam int IMW = INPUT_MANTISSA_WIDTH;
    localparam int EW  = ((IEW > OUTPUT_EXPONENT_WIDTH) ? IEW : OUTPUT_EXPONENT_WIDTH) + 3;
    localparam int PW  = 2 * (IMW + 1);
    localparam int MW  = 4 + EW + PW;
    localparam logic [EW-1:0] BIAS_ADJ = EW'(2 * INPUT_EXPONENT_BIAS - OUTPUT_EXPONENT_BIAS);

    function automatic fp_class_e classify(input logic [IEW-1:0] e, input logic [IMW-1:0] m);
        if (e == '1) return (m != '0) ? FpNan : FpInf;
        if (e == '0) return FpZero;
        return FpNormal;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: classify, sign, exponent sum and raw mantissa product.
    fp_class_e      cls_a, cls_b;
    logic [EW-1:0]  exp_sum;
    logic [PW-1:0]  prod;
    logic           s1_nan, s1_inf, s1_zero, s1_sign;
    logic [MW-1:0]  s1_word;

    assign cls_a   = classify(a[IEW+IMW-1 -: IEW], a[IMW-1:0]);
    assign cls_b   = classify(b[IEW+IMW-1 -: IEW], b[IMW-1:0]);
    assign s1_nan  = (cls_a == FpNan) || (cls_b == FpNan)
                     || (cls_a == FpInf && cls_b == FpZero)
                     || (cls_a == FpZero && cls_b == FpInf);
    assign s1_inf  = (cls_a == FpInf) || (cls_b == FpInf);
    assign s1_zero = (cls_a == FpZero) || (cls_b == FpZero);
    assign s1_sign = a[INPUT_WIDTH-1] ^ b[INPUT_WIDTH-1];
    assign exp_sum = EW'(a[IEW+IMW-1 -: IEW]) + EW'(b[IEW+IMW-1 -: IEW]) + BIAS_ADJ;
    assign prod    = PW'({1'b1, a[IMW-1:0]}) * PW'({1'b1, b[IMW-1:0]});
    assign s1_word = {s1_nan, s1_inf, s1_zero, s1_sign, exp_sum, prod};

    logic [MW-1:0] rp_word;
    logic          rp_vld;

    if (PIPE_STAGES == 1) begin : g_no_mid
        assign rp_word = s1_word;
        assign rp_vld  = in_valid;
    end else begin : g_mid
        logic [MW-1:0]          mid_q [PIPE_STAGES-1];
        logic [PIPE_STAGES-2:0] mid_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mid_vld_q <= '0;
                for (int i = 0; i < PIPE_STAGES - 1; i++) mid_q[i] <= '0;
            end else if (en) begin
                mid_vld_q[0] <= in_valid;
                mid_q[0]     <= s1_word;
                for (int i = 1; i < PIPE_STAGES - 1; i++) begin
                    mid_vld_q[i] <= mid_vld_q[i-1];
                    mid_q[i]     <= mid_q[i-1];
                end
            end
        end

        assign rp_word = mid_q[PIPE_STAGES-2];
        assign rp_vld  = mid_vld_q[PIPE_STAGES-2];
    end

    logic [OUTPUT_WIDTH-1:0] rp_y;
    logic [OUTPUT_WIDTH-1:0] y_q;
    logic                    out_valid_q;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    logic [3:0]              rp_flags;
    logic [3:0]              flags_q;
`endif

    fp_round_pack #(
        .IN_MAN_WIDTH  (IMW),
        .OUT_EXP_WIDTH (OUTPUT_EXPONENT_WIDTH),
        .OUT_MAN_WIDTH (OUTPUT_MANTISSA_WIDTH),
        .EXP_WIDTH     (EW)
    ) u_round_pack (
        .special_nan  (rp_word[MW-1]),
        .special_inf  (rp_word[MW-2]),
        .special_zero (rp_word[MW-3]),
        .sign         (rp_word[MW-4]),
        .exp_sum      (rp_word[PW +: EW]),
        .prod         (rp_word[PW-1:0]),
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
        .flags        (rp_flags),
`endif
        .y            (rp_y)
    );

    // Output register keeps the last result through bubbles so y never glitches to junk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
            flags_q     <= '0;
`endif
        end else if (en) begin
            out_valid_q <= rp_vld;
            if (rp_vld) begin
                y_q     <= rp_y;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
                flags_q <= rp_flags;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Self-checking bench: bf16 x bf16 vector table through a scoreboard plus an fp32 rounding instance.
module tb_fp_multiplier_pipe;

    localparam int P    = 2;
    localparam int P32  = 3;
    localparam int NVEC = 16;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] y;
        logic [3:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  flags;
        logic        lat;
        logic [31:0] stamp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b;
    logic [31:0] y;
    logic        v_in32, rdy32, v_out32;
    logic [31:0] a32, b32, y32;
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
    logic [3:0]  flags, flags32;
`endif

    fp_multiplier_pipe #(.PIPE_STAGES(P)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
        .flags     (flags),
`endif
        .y         (y)
    );

    fp_multiplier_pipe #(
        .INPUT_EXPONENT_WIDTH (8),
        .INPUT_MANTISSA_WIDTH (23),
        .INPUT_EXPONENT_BIAS  (-127),
        .PIPE_STAGES          (P32)
    ) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v_in32),
        .in_ready  (rdy32),
        .a         (a32),
        .b         (b32),
        .out_valid (v_out32),
        .out_ready (1'b1),
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
        .flags     (flags32),
`endif
        .y         (y32)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t vecs[NVEC];
    logic [31:0] cur_y;
    logic [3:0]  cur_flags;
    logic        lat_mode = 1'b0;
    logic        bp_mode  = 1'b0;
    logic [3:0]  bp_pat   = 4'b1001;
    int          bp_idx   = 0;
    int unsigned negcnt   = 0;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_y   = '0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        negcnt = negcnt + 1;
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            check(in_ready == (!out_valid || out_ready), "in_ready_eq_en", 32'(in_ready),
                  32'(!out_valid || out_ready));
            if (hold_chk) check(y == hold_y, "y_stable_stalled", y, hold_y);
            hold_chk = out_valid && !out_ready;
            hold_y   = y;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", y, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check(y == e.y, "result_y", y, e.y);
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
                    check(flags == e.flags, "result_flags", 32'(flags), 32'(e.flags));
`endif
                    if (e.lat) check(negcnt - e.stamp == P, "latency", negcnt - e.stamp, P);
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{y: cur_y, flags: cur_flags,
                                                        lat: lat_mode, stamp: negcnt});
        end
    end

    always @(posedge clk) begin
        if (bp_mode) begin
            #1;
            out_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end
    end

    task automatic send(input vec_t v);
        bit ok;
        int guard;
        guard     = 0;
        a         = v.a;
        b         = v.b;
        cur_y     = v.y;
        cur_flags = v.flags;
        in_valid  = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 100);
        if (!ok) check(1'b0, "accept_timeout", 32'(guard), 32'd100);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'h0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] ey,
                          input logic [3:0] ef);
        int cnt;
        cnt    = 0;
        a32    = va;
        b32    = vb;
        v_in32 = 1'b1;
        @(negedge clk);
        check(rdy32 == 1'b1, "fp32_in_ready", 32'(rdy32), 32'h1);
        @(posedge clk);
        #1;
        v_in32 = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!v_out32 && cnt < 20);
        check(cnt == P32, "fp32_latency", 32'(cnt), P32);
        check(y32 == ey, "fp32_y", y32, ey);
`ifdef FP_MULTIPLIER_PIPE_FLAGS_EN
        check(flags32 == ef, "fp32_flags", 32'(flags32), 32'(ef));
`else
        if (ef != ef) check(1'b0, "fp32_flags_unused", 32'(ef), 32'(ef));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {a, b, y, flags{invalid, overflow, underflow, inexact}}
        vecs[0]  = '{16'h4040, 16'h4248, 32'h43160000, 4'h0};
        vecs[1]  = '{16'h7F80, 16'h0000, 32'h7FC00000, 4'h8};
        vecs[2]  = '{16'hFF80, 16'h3F80, 32'hFF800000, 4'h0};
        vecs[3]  = '{16'h8000, 16'h4000, 32'h80000000, 4'h0};
        vecs[4]  = '{16'h7F00, 16'h7F00, 32'h7F800000, 4'h5};
        vecs[5]  = '{16'h0080, 16'h0080, 32'h00000000, 4'h3};
        vecs[6]  = '{16'h7FC1, 16'h3F80, 32'h7FC00000, 4'h8};
        vecs[7]  = '{16'h3F80, 16'h3F80, 32'h3F800000, 4'h0};
        vecs[8]  = '{16'hC000, 16'h4040, 32'hC0C00000, 4'h0};
        vecs[9]  = '{16'h7F80, 16'h7F80, 32'h7F800000, 4'h0};
        vecs[10] = '{16'h0001, 16'h4000, 32'h00000000, 4'h0};
        vecs[11] = '{16'hFF80, 16'h8000, 32'h7FC00000, 4'h8};
        vecs[12] = '{16'h3F00, 16'h0080, 32'h00000000, 4'h3};
        vecs[13] = '{16'h3F00, 16'h0100, 32'h00800000, 4'h0};
        vecs[14] = '{16'h7F00, 16'h3F80, 32'h7F000000, 4'h0};
        vecs[15] = '{16'h7F00, 16'h4000, 32'h7F800000, 4'h5};

        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        v_in32    = 1'b0;
        a32       = '0;
        b32       = '0;
        cur_y     = '0;
        cur_flags = '0;

        #12;
        check(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'h0);
        check(y == 32'h0, "reset_y", y, 32'h0);
        check(v_out32 == 1'b0, "reset_out_valid32", 32'(v_out32), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(in_ready == 1'b1, "ready_after_reset", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        lat_mode = 1'b1;
        send(vecs[0]);
        drain();
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        drain();

        lat_mode = 1'b0;
        bp_mode  = 1'b1;
        for (int i = 0; i < 10; i++) send(vecs[(i * 3 + 1) % NVEC]);
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Two pairs in flight, then an asynchronous reset.
        send(vecs[7]);
        send(vecs[8]);
        check(out_valid == 1'b1, "two_in_flight", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "reset_drops_valid", 32'(out_valid), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send(vecs[0]);
        drain();

        send32(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1);
        send32(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1);
        send32(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1);
        send32(32'h40400000, 32'h42480000, 32'h43160000, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_multiplier_pipe.md
Name: fp_multiplier_pipe

Overview:
- Pipelined, parametrised successor to the combinational fp_multiplier. Same format-conversion role (default bfloat16 x bfloat16 -> IEEE-754 fp32).
- Adds a valid/ready stream interface, configurable pipeline depth, round-to-nearest-even rounding and IEEE special-value handling.
- Sits between operand-fetch and accumulator stages of the MAC datapath.

Parameters:
- INPUT_EXPONENT_WIDTH, 8, input exponent bits
- INPUT_MANTISSA_WIDTH, 7, input stored mantissa bits
- INPUT_EXPONENT_BIAS, -127, signed bias added to a stored exponent to get the true exponent
- OUTPUT_EXPONENT_WIDTH, 8, output exponent bits
- OUTPUT_MANTISSA_WIDTH, 23, output stored mantissa bits
- OUTPUT_EXPONENT_BIAS, -127, signed output bias
- PIPE_STAGES, 2, register stages from input to output; legal range 1..4
- Derived: INPUT_WIDTH = 1+IEW+IMW; OUTPUT_WIDTH = 1+OEW+OMW

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset: asynchronous assert, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  INPUT_WIDTH  operand {sign, exponent, mantissa}
- b  in  INPUT_WIDTH  operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  OUTPUT_WIDTH  product {sign, exponent, mantissa}

Behaviour:
- Reset: all stage valid bits = 0, out_valid = 0, y = 0. in_ready = 1 while rst_n is high and the pipe is not stalled.
- Stall model: global enable en = !out_valid || out_ready. in_ready = en (a combinational path from out_ready to in_ready is accepted).
- Transfer: a pair is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- When en = 0, every stage holds, including its valid bit. Bubbles advance only when en = 1.
- Latency: exactly PIPE_STAGES cycles accept-to-out_valid when unstalled. Throughput: 1 result per cycle.
- Ordering: results leave strictly in acceptance order. There are no drops and no duplicates under any out_ready pattern.
- Stage split:
  - S1: unpack, classify, sign xor, exponent sum, mantissa product.
  - Last stage: normalise, round, pack.
  - Stages in between are pure pipeline registers.
- Arithmetic:
  - sy = sa ^ sb.
  - Implicit-1 mantissas; product width 2*(IMW+1).
  - Exponent in signed (max(IEW,OEW)+3)-bit arithmetic: e = ea + eb + 2*INPUT_EXPONENT_BIAS - OUTPUT_EXPONENT_BIAS.
  - If the product MSB is set, shift right 1 and e += 1.
- Rounding: round-to-nearest-even when the product fraction exceeds OMW. A rounding carry renormalises and increments e. With the defaults the product is exact (16 bits into 24).
- Special cases, priority order:
  1. Either input NaN, or inf x 0: canonical qNaN, sign 0, exponent all-ones, mantissa MSB only set.
  2. Either input inf: signed inf.
  3. Either input has exponent 0 (zero or subnormal, flushed): signed zero.
- Overflow: e >= 2^OEW-1 -> signed inf.
- Underflow: e <= 0 -> signed zero (flush-to-zero, no subnormal outputs).
- Reset mid-operation: in-flight results are discarded; out_valid drops asynchronously.

Optional Feature:
- Macro: FP_MULTIPLIER_PIPE_FLAGS_EN.
- With the macro defined: adds output port flags[3:0] = {invalid, overflow, underflow, inexact}.
  - flags are registered alongside y and valid only with out_valid.
  - inexact is set when rounding discards nonzero bits, or on overflow/underflow.
  - Reset value is 0.
- Without the macro: the port and its logic are absent. y is bit-identical in both builds.

Decomposition:
- Package fp_multiplier_pkg:
  - fp class enum (ZERO, NORMAL, INF, NAN).
  - flag bit index constants.
  - Default bfloat16/fp32 width and bias constants.
  - Canonical-NaN construction function.
- Sub-module fp_round_pack: combinational normalise, RNE round, overflow/underflow and pack. It is instantiated in the last stage.

Test Plan:
- 3.0 x 50.0: a=0x4040, b=0x4248, out_ready=1 -> y=0x43160000, out_valid exactly PIPE_STAGES cycles after accept.
- Specials: 0x7F80 x 0x0000 -> 0x7FC00000 (invalid flag set). 0xFF80 x 0x3F80 -> 0xFF800000. 0x8000 x 0x4000 -> 0x80000000.
- Overflow/underflow: 0x7F00 x 0x7F00 -> 0x7F800000 (overflow flag). 0x0080 x 0x0080 -> 0x00000000 (underflow flag).
- Backpressure: stream 10 back-to-back pairs with out_ready toggling 1,0,0,1,... -> in_ready == en every cycle, all 10 results emerge in order, y stable while out_valid && !out_ready.
- Reset mid-stream: assert rst_n=0 with 2 results in flight -> out_valid=0 immediately. After release, the first new pair is the first result produced.
- Rounding (IMW=23, OMW=23, PIPE_STAGES=3, fp32 in/out): 0x3F800001 x 0x3F800001 -> 0x3F800002 (round to even, inexact).
